// File: rtl/uart_pkg.sv
// Shared types for the UART transmit framer: FSM state encoding and parity selection.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // data_xor is the XOR of all data bits; odd parity inverts it.
  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period counter for the UART framer: pulses bit_done on the last CLK of each serial bit.
module uart_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic run,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_done = run && (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves cnt_d unassigned (latch).
    cnt_d = '0;
    if (run && !bit_done) cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA_WIDTH bits LSB-first, optional parity, 1 or 2 stop bits,
// with back-to-back chaining when a new word is accepted in the final stop cycle.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  Ready,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  stop2_q, stop2_d;
  logic                  stop_idx_q, stop_idx_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bit_done;
  logic                  last_stop;
  logic                  accept;

  uart_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .CLK     (CLK),
    .RST     (RST),
    .run     (state_q != IDLE),
    .bit_done(bit_done)
  );

  // Ready depends only on registered state, so a source may tie Data_Valid to Ready freely.
  assign last_stop = (state_q == STOP) && bit_done && (stop_idx_q || !stop2_q);
  assign Ready     = (state_q == IDLE) || last_stop;
  assign accept    = Data_Valid && Ready;
  assign TX_OUT    = tx_q;
  assign Busy      = busy_q;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;

    case (state_q)
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == IDX_LAST) begin
            idx_d      = '0;
            stop_idx_d = 1'b0;
            state_d    = par_en_q ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          stop_idx_d = 1'b0;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (last_stop)     state_d    = IDLE;
        else if (bit_done) stop_idx_d = 1'b1;
      end
      default: ;
    endcase

    // Accept is only possible in IDLE or the final stop cycle, so it overrides either.
    if (accept) begin
      state_d    = START;
      word_d     = P_DATA;
      par_en_d   = PAR_EN;
      par_typ_d  = PAR_TYP;
      stop2_d    = STOP2;
      idx_d      = '0;
      stop_idx_d = 1'b0;
    end

    // Outputs are decoded from the next state so TX_OUT and Busy are registered.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = word_d[idx_d];
      PARITY:  tx_d = parity_bit(^word_d, par_typ_d);
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  // NOTE: the data word is a plain register with no reset; it is always loaded before it is read.
  always_ff @(posedge CLK) begin
    word_q <= word_d;
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: two instances (1 and 4 CLKs per bit) checked cycle by cycle
// against per-cycle line levels expanded from the frame format at accept time.
module tb_uart_tx_frame;

  localparam int DW   = 8;
  localparam int CPB0 = 1;
  localparam int CPB1 = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] pd    [2];
  logic          dv    [2];
  logic          pe    [2];
  logic          pt    [2];
  logic          s2    [2];
  logic          ready [2];
  logic          tx    [2];
  logic          busy  [2];

  logic exp_q [2][$];
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB0)) u_dut0 (
    .CLK(clk), .RST(rst), .P_DATA(pd[0]), .Data_Valid(dv[0]), .PAR_EN(pe[0]),
    .PAR_TYP(pt[0]), .STOP2(s2[0]), .Ready(ready[0]), .TX_OUT(tx[0]), .Busy(busy[0])
  );

  uart_tx_frame #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB1)) u_dut1 (
    .CLK(clk), .RST(rst), .P_DATA(pd[1]), .Data_Valid(dv[1]), .PAR_EN(pe[1]),
    .PAR_TYP(pt[1]), .STOP2(s2[1]), .Ready(ready[1]), .TX_OUT(tx[1]), .Busy(busy[1])
  );

  task automatic check(input string name, input int sel, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=%b expected=%b", name, sel, $time, act, exp);
    end
  endtask

  // Expand a frame into one expected line level per CLK cycle.
  task automatic push_frame(input int sel, input logic [DW-1:0] d, input logic p_en,
                            input logic p_typ, input logic st2);
    logic bits [$];
    int   ones;
    int   cpb;
    logic p;
    cpb  = (sel == 0) ? CPB0 : CPB1;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      bits.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (p_en) begin
      p = (ones % 2 == 1);
      if (p_typ) p = !p;
      bits.push_back(p);
    end
    bits.push_back(1'b1);
    if (st2) bits.push_back(1'b1);
    foreach (bits[i])
      for (int k = 0; k < cpb; k++) exp_q[sel].push_back(bits[i]);
  endtask

  // Monitor: every cycle, compare line, Busy and Ready against the head of the expected stream.
  always @(negedge clk) begin
    int   n;
    logic e_tx;
    if (mon_en) begin
      for (int s = 0; s < 2; s++) begin
        n    = exp_q[s].size();
        e_tx = (n > 0) ? exp_q[s][0] : 1'b1;
        check("tx_out", s, tx[s], e_tx);
        check("busy", s, busy[s], n > 0);
        check("ready", s, ready[s], n <= 1);
        if (n > 0) void'(exp_q[s].pop_front());
        if (rst) exp_q[s].delete();
      end
    end
  end

  task automatic send(input int sel, input logic [DW-1:0] d, input logic p_en,
                      input logic p_typ, input logic st2);
    bit acc;
    acc = 1'b0;
    pd[sel] = d;
    pe[sel] = p_en;
    pt[sel] = p_typ;
    s2[sel] = st2;
    dv[sel] = 1'b1;
    for (int c = 0; c < 400 && !acc; c++) begin
      @(negedge clk);
      acc = ready[sel] && !rst;
      @(posedge clk);
    end
    if (acc) begin
      push_frame(sel, d, p_en, p_typ, st2);
    end else begin
      checks++;
      failures++;
      $display("FAIL accept_timeout dut%0d data=%h never accepted", sel, d);
    end
    #1;
    dv[sel] = 1'b0;
    // Scramble inputs mid-frame; only values at accept may matter.
    pd[sel] = DW'($urandom);
    pe[sel] = 1'($urandom);
    pt[sel] = 1'($urandom);
    s2[sel] = 1'($urandom);
  endtask

  task automatic wait_idle(input int sel);
    for (int c = 0; c < 2000 && exp_q[sel].size() != 0; c++) @(posedge clk);
    if (exp_q[sel].size() != 0) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout dut%0d remaining=%0d expected=0", sel, exp_q[sel].size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      pd[s] = '0; dv[s] = 1'b0; pe[s] = 1'b0; pt[s] = 1'b0; s2[s] = 1'b0;
    end
    @(posedge clk);
    #1 mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed frames at one CLK per bit.
    send(0, 8'hA5, 1'b1, 1'b0, 1'b0);
    wait_idle(0);
    send(0, 8'h01, 1'b1, 1'b1, 1'b0);
    wait_idle(0);
    send(0, 8'h01, 1'b1, 1'b0, 1'b0);
    wait_idle(0);

    // Back-to-back chaining: second word waits on Ready with Data_Valid held.
    send(0, 8'h55, 1'b0, 1'b0, 1'b0);
    send(0, 8'hAA, 1'b0, 1'b0, 1'b0);
    wait_idle(0);

    // Reset during data bit 3 abandons the frame; the next word goes out cleanly.
    send(0, 8'hB7, 1'b1, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(0, 8'h0F, 1'b0, 1'b0, 1'b0);
    wait_idle(0);

    // Data_Valid pulsed mid-frame while Ready is low must be ignored.
    send(0, 8'hC3, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    pd[0] = 8'hFF;
    dv[0] = 1'b1;
    @(posedge clk);
    #1 dv[0] = 1'b0;
    wait_idle(0);

    // Four CLKs per bit, two stop bits, no parity.
    send(1, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_idle(1);

    // Randomized frames with random gaps, including immediate chaining.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(0, DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    wait_idle(0);
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
      end
      send(1, DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    wait_idle(1);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
